// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect and in-flight discard.
// Define FETCH_PERF_COUNT_EN to add the perf_fetched/perf_stall counters.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        icache_read_enable,
    output logic [63:0] icache_address,
    input  logic [31:0] icache_data,
    input  logic        icache_send_enable,
    output logic        icache_jump_reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [63:0] fetch_pc,
    input  logic        decode_ready
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_stall
`endif
);
    typedef enum logic [1:0] {REQUEST, RELEASE, HOLD} state_t;
    state_t state;
    logic [63:0] pc, req_pc, target, next_req;
    logic discard, consume, hold_out;
    assign target = redirect_pc & ~64'h3;
    assign next_req = redirect_valid ? target : pc;
    assign consume = fetch_valid && decode_ready;
    assign hold_out = fetch_valid && !decode_ready && !redirect_valid;
    assign icache_read_enable = state == REQUEST;
    assign icache_address = req_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= REQUEST;
            pc <= RESET_PC;
            req_pc <= RESET_PC;
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            fetch_pc <= '0;
            icache_jump_reset <= 1'b0;
            discard <= 1'b0;
        end else begin
            icache_jump_reset <= 1'b0;
            if (consume) fetch_valid <= 1'b0;
            case (state)
                REQUEST: begin
                    if (icache_send_enable) begin
                        state <= RELEASE;
                        if (discard) begin
                            discard <= 1'b0;
                        end else if (!redirect_valid) begin
                            fetch_valid <= 1'b1;
                            fetch_instr <= icache_data;
                            fetch_pc <= req_pc;
                            pc <= req_pc + 64'd4;
                        end
                    end else if (redirect_valid) begin
                        // The cache still owes a response for req_pc; drop it when it lands.
                        discard <= 1'b1;
                        icache_jump_reset <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!icache_send_enable) begin
                        state <= hold_out ? HOLD : REQUEST;
                        if (!hold_out) req_pc <= next_req;
                    end
                end
                HOLD: begin
                    if (decode_ready || redirect_valid) begin
                        state <= REQUEST;
                        req_pc <= next_req;
                    end
                end
                default: state <= REQUEST;
            endcase
            if (redirect_valid) begin
                pc <= target;
                fetch_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall <= '0;
        end else begin
            if (consume) perf_fetched <= perf_fetched + 64'd1;
            if (fetch_valid && !decode_ready) perf_stall <= perf_stall + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios against a 1-cycle-hit cache model and a sequential-PC reference.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam logic [63:0] RPC = 64'h1000;
    logic        clock = 1'b0;
    logic        reset;
    logic        icache_read_enable;
    logic [63:0] icache_address;
    logic [31:0] icache_data;
    logic        icache_send_enable;
    logic        icache_jump_reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [63:0] fetch_pc;
    logic        decode_ready;
`ifdef FETCH_PERF_COUNT_EN
    logic [63:0] perf_fetched, perf_stall;
`endif
    int checks = 0;
    int failures = 0;
    int jr_count = 0;
    logic [63:0] cons[$];
    logic [31:0] cons_instr[$];

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clock(clock),
        .reset(reset),
        .icache_read_enable(icache_read_enable),
        .icache_address(icache_address),
        .icache_data(icache_data),
        .icache_send_enable(icache_send_enable),
        .icache_jump_reset(icache_jump_reset),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_pc(fetch_pc),
        .decode_ready(decode_ready)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_consumes(input int n);
        for (int i = 0; i < 100 && cons.size() < n; i++) step(1);
        if (cons.size() < n) chk("consume_timeout", 64'(cons.size()), 64'(n));
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100 && !fetch_valid; i++) step(1);
        chk("wait_valid", fetch_valid, 1'b1);
    endtask

    // Cache with 1-cycle hits: answers each request once, shares the fetch reset.
    always @(posedge clock) begin
        if (reset) icache_send_enable <= 1'b0;
        else begin
            icache_send_enable <= icache_read_enable && !icache_send_enable;
            icache_data <= word_at(icache_address);
        end
    end

    // Reference: outputs appear in program order from exp_pc; a redirect restarts the order at the target.
    initial begin
        logic [63:0] exp_pc;
        logic drop, prev_redirect, valid_due, exp_jr;
        exp_pc = RPC;
        drop = 0;
        prev_redirect = 0;
        valid_due = 0;
        exp_jr = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_pc = RPC;
                drop = 0;
                prev_redirect = 0;
                valid_due = 0;
                exp_jr = 0;
            end else begin
                chk("jump_reset", icache_jump_reset, exp_jr);
                if (prev_redirect) chk("redirect_clears_valid", fetch_valid, 1'b0);
                if (valid_due) chk("hit_latency", fetch_valid, 1'b1);
                chk("no_request_while_valid", fetch_valid && icache_read_enable, 1'b0);
                if (fetch_valid) begin
                    chk("out_pc", fetch_pc, exp_pc);
                    chk("out_instr", fetch_instr, word_at(exp_pc));
                end
                if (icache_jump_reset) jr_count++;
                exp_jr = redirect_valid && icache_read_enable && !icache_send_enable;
                valid_due = icache_read_enable && icache_send_enable && !drop && !redirect_valid;
                if (valid_due) chk("req_addr", icache_address, exp_pc);
                if (icache_read_enable && icache_send_enable) drop = 0;
                if (exp_jr) drop = 1;
                if (fetch_valid && decode_ready && !redirect_valid) begin
                    cons.push_back(fetch_pc);
                    cons_instr.push_back(fetch_instr);
                    exp_pc += 64'd4;
                end
                if (redirect_valid) exp_pc = redirect_pc & ~64'h3;
                prev_redirect = redirect_valid;
            end
        end
    end

    initial begin
        int base, jr0;
        reset = 1;
        redirect_valid = 0;
        redirect_pc = '0;
        decode_ready = 1;
        step(3);
        chk("rst_valid", fetch_valid, 1'b0);
        chk("rst_read_en", icache_read_enable, 1'b1);
        chk("rst_addr", icache_address, RPC);
        chk("rst_jump_reset", icache_jump_reset, 1'b0);
        chk("rst_fetch_pc", fetch_pc, 64'h0);
        chk("rst_fetch_instr", fetch_instr, 64'h0);
        reset = 0;
        // In-order stream with decode always ready.
        base = cons.size();
        wait_consumes(base + 3);
        chk("seq_pc0", cons[base], 64'h1000);
        chk("seq_pc1", cons[base + 1], 64'h1004);
        chk("seq_pc2", cons[base + 2], 64'h1008);
        chk("seq_instr0", cons_instr[base], 64'h1357_8BDF);
        // Decode stalls for 5 cycles on the next output.
        decode_ready = 0;
        wait_valid();
        chk("stall_first_pc", fetch_pc, 64'h100C);
        chk("stall_first_instr", fetch_instr, 64'h1357_8BD3);
        repeat (5) begin
            step(1);
            chk("stall_valid", fetch_valid, 1'b1);
            chk("stall_pc", fetch_pc, 64'h100C);
            chk("stall_read_en", icache_read_enable, 1'b0);
        end
        decode_ready = 1;
        base = cons.size();
        wait_consumes(base + 1);
        chk("stall_release_pc", cons[base], 64'h100C);
        // Reset while a hit is in flight.
        for (int i = 0; i < 50 && !(icache_read_enable && icache_send_enable); i++) step(1);
        reset = 1;
        step(1);
        reset = 0;
        chk("midreset_valid", fetch_valid, 1'b0);
        chk("midreset_addr", icache_address, RPC);
        base = cons.size();
        wait_consumes(base + 1);
        chk("midreset_pc", cons[base], 64'h1000);
        // Redirect while the request for 0x1004 is outstanding.
        for (int i = 0; i < 50 && !(icache_read_enable && icache_address == 64'h1004 && !icache_send_enable); i++) step(1);
        jr0 = jr_count;
        redirect_valid = 1;
        redirect_pc = 64'h2003;
        step(1);
        redirect_valid = 0;
        chk("redir_req_jr", icache_jump_reset, 1'b1);
        step(1);
        chk("redir_req_jr_end", icache_jump_reset, 1'b0);
        base = cons.size();
        wait_consumes(base + 1);
        chk("redir_req_pc", cons[base], 64'h2000);
        chk("redir_req_jr_count", 64'(jr_count - jr0), 64'd1);
        // Redirect coinciding with a consume.
        wait_valid();
        jr0 = jr_count;
        redirect_valid = 1;
        redirect_pc = 64'h3000;
        step(1);
        redirect_valid = 0;
        chk("redir_consume_valid", fetch_valid, 1'b0);
        base = cons.size();
        wait_consumes(base + 1);
        chk("redir_consume_pc", cons[base], 64'h3000);
        chk("redir_consume_no_jr", 64'(jr_count - jr0), 64'd0);
        // Wrap at the top of the address space.
        wait_valid();
        redirect_valid = 1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step(1);
        redirect_valid = 0;
        base = cons.size();
        wait_consumes(base + 1);
        chk("wrap_top_pc", cons[base], 64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 50 && !icache_read_enable; i++) step(1);
        chk("wrap_addr", icache_address, 64'h0);
        wait_consumes(base + 2);
        chk("wrap_zero_pc", cons[base + 1], 64'h0);
        chk("wrap_zero_instr", cons_instr[base + 1], 64'h1357_9BDF);
`ifdef FETCH_PERF_COUNT_EN
        reset = 1;
        step(2);
        reset = 0;
        chk("perf_rst_fetched", perf_fetched, 64'd0);
        chk("perf_rst_stall", perf_stall, 64'd0);
        decode_ready = 0;
        wait_valid();
        step(4);
        decode_ready = 1;
        base = cons.size();
        wait_consumes(base + 3);
        chk("perf_fetched", perf_fetched, 64'd3);
        chk("perf_stall", perf_stall, 64'd4);
`endif
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
